branch_resolver: RTL and testbench
==================================

Name: branch_resolver

Overview:
- Consumes the branch comparator's BrEq/BrLT flags and drives its BrUn select.
- Accepts one branch per cycle from decode/execute through a valid/ready handshake.
- Decodes funct3 into a taken/not-taken decision and computes the next-PC target.
- Reports mispredictions against the fetch-stage prediction, holds a multi-cycle flush window, and keeps saturating branch and mispredict counters.

Parameters:
- XLEN, 32, datapath width of PC, immediate and target.
- FLUSH_CYCLES, 2, number of cycles flush stays high after a mispredict (legal values 1 to 7).
- CNT_W, 16, width of the statistics counters.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- br_valid  in  1  branch request valid.
- br_ready  out  1  resolver can accept a request.
- br_funct3  in  3  RV32I branch funct3.
- br_pc  in  XLEN  PC of the branch instruction.
- br_imm  in  XLEN  sign-extended B-type immediate.
- br_pred_taken  in  1  prediction made at fetch.
- BrUn  out  1  unsigned-compare select to the comparator (combinational).
- BrEq  in  1  comparator equal flag, valid in the same cycle as the request.
- BrLT  in  1  comparator less-than flag, valid in the same cycle as the request.
- res_valid  out  1  one-cycle pulse carrying a resolved branch.
- res_taken  out  1  branch outcome.
- res_target  out  XLEN  next PC.
- res_mispredict  out  1  outcome differs from prediction.
- res_illegal  out  1  funct3 was 010 or 011.
- flush  out  1  kill the younger pipeline stages.
- cnt_clr  in  1  synchronous clear of both counters.
- br_count  out  CNT_W  accepted legal branches.
- mis_count  out  CNT_W  mispredicts.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; res_valid, res_taken, res_mispredict, res_illegal, flush = 0; res_target = 0; br_count = mis_count = 0; flush counter = 0. br_ready = 0 while rst_n is low.
- BrUn = br_funct3[1], purely combinational from the input, independent of br_valid.
- Accept: a request is accepted when br_valid and br_ready are both high at a rising edge.
- br_ready: high in IDLE and RESOLVE, low in FLUSH.
- Decision, evaluated in the accept cycle:
  - 000 taken=BrEq; 001 taken=!BrEq.
  - 100 and 110 taken=BrLT; 101 and 111 taken=!BrLT.
  - 010 and 011: taken=0, res_illegal=1, res_mispredict=0, counters untouched.
- Target: pc+imm if taken, else pc+4, modulo 2^XLEN (carry discarded).
- Latency: accepted in cycle N, results registered and res_valid=1 in cycle N+1 only. res_* fields hold their values until the next accept.
- mispredict = legal and (taken != br_pred_taken).
- States:
  - IDLE: on accept go to RESOLVE.
  - RESOLVE: on accept with mispredict go to FLUSH. On accept without mispredict stay in RESOLVE; back-to-back accepts give one result per cycle. With no accept, return to IDLE.
  - FLUSH: flush=1 from cycle N+1 for exactly FLUSH_CYCLES cycles, counted by an internal down-counter loaded with FLUSH_CYCLES-1. Return to IDLE when the counter reads 0 and flush is high.
- br_valid arriving during FLUSH is not accepted. The requester holds its request, and it is accepted in the first cycle after FLUSH ends.
- A mispredicting branch accepted in RESOLVE immediately after a correct branch enters FLUSH normally.
- Counters:
  - br_count increments on each legal accept.
  - mis_count increments on each mispredicting accept.
  - Both saturate at 2^CNT_W-1 and do not wrap.
  - cnt_clr has priority: if it coincides with an increment, the counter is 0 next cycle.
- Reset asserted mid-FLUSH: flush drops immediately (asynchronously); the pending result is discarded.

Test Plan:
- BEQ, BrEq=1, pc=0x100, imm=0x20, pred=1, accept at N -> N+1: res_valid=1, taken=1, target=0x120, mispredict=0, flush=0, br_count=1.
- BLTU (110) -> BrUn=1 in the same cycle. BrLT=0, pred=1 -> taken=0, target=pc+4, mispredict=1, flush high for exactly 2 cycles, br_ready low for those 2 cycles, mis_count=1.
- Back-to-back: three correctly predicted BNE accepted on consecutive cycles -> three consecutive res_valid pulses, br_ready stays 1, br_count=3.
- br_valid held during FLUSH -> not accepted until the cycle after flush falls. Wrap case: pc=0xFFFFFFFC, not taken -> target=0x00000000.
- funct3=010 -> res_illegal=1, taken=0, no flush, counters unchanged.
- Preload br_count to 0xFFFF and accept a branch -> stays 0xFFFF.
- cnt_clr coincident with an accept -> both counters 0 next cycle.
- rst_n pulsed low mid-FLUSH -> flush=0 immediately and state returns to IDLE.

Source files
------------

// File: rtl/branch_resolver.sv
// Branch resolution unit: decides taken/not-taken from comparator flags, computes next PC,
// flags mispredictions with a timed flush window and keeps saturating statistics.
module branch_resolver #(
    parameter int XLEN         = 32,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             br_valid,
    output logic             br_ready,
    input  logic [2:0]       br_funct3,
    input  logic [XLEN-1:0]  br_pc,
    input  logic [XLEN-1:0]  br_imm,
    input  logic             br_pred_taken,
    output logic             BrUn,
    input  logic             BrEq,
    input  logic             BrLT,
    output logic             res_valid,
    output logic             res_taken,
    output logic [XLEN-1:0]  res_target,
    output logic             res_mispredict,
    output logic             res_illegal,
    output logic             flush,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] br_count,
    output logic [CNT_W-1:0] mis_count
);

    // state   | meaning
    // IDLE    | no branch resolved last cycle, ready for a request
    // RESOLVE | a branch was resolved last cycle, ready for back-to-back requests
    // FLUSH   | mispredict recovery, younger stages killed, requests stalled
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] RESOLVE = 2'd1;
    localparam logic [1:0] FLUSH   = 2'd2;

    localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    logic [1:0]      state;
    logic [2:0]      flushCnt;
    logic            accept;
    logic            isLegal;
    logic            brTaken;
    logic            isMis;
    logic [XLEN-1:0] nextPc;

    assign BrUn     = br_funct3[1];
    assign br_ready = rst_n && (state != FLUSH);
    assign accept   = br_valid && br_ready;
    assign isLegal  = (br_funct3[2:1] != 2'b01);

    always_comb begin
        brTaken = 1'b0;
        case (br_funct3)
            3'b000:         brTaken = BrEq;
            3'b001:         brTaken = !BrEq;
            3'b100, 3'b110: brTaken = BrLT;
            3'b101, 3'b111: brTaken = !BrLT;
            default:        brTaken = 1'b0;
        endcase
    end

    assign isMis  = isLegal && (brTaken != br_pred_taken);
    assign nextPc = brTaken ? (br_pc + br_imm) : (br_pc + XLEN'(4));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            flushCnt       <= '0;
            flush          <= 1'b0;
            res_valid      <= 1'b0;
            res_taken      <= 1'b0;
            res_target     <= '0;
            res_mispredict <= 1'b0;
            res_illegal    <= 1'b0;
        end else begin
            res_valid <= accept;
            if (accept) begin
                res_taken      <= brTaken;
                res_target     <= nextPc;
                res_mispredict <= isMis;
                res_illegal    <= !isLegal;
            end
            case (state)
                IDLE, RESOLVE: begin
                    if (accept && isMis) begin
                        state    <= FLUSH;
                        flush    <= 1'b1;
                        flushCnt <= FLUSH_LOAD;
                    end else if (accept) begin
                        state <= RESOLVE;
                    end else begin
                        state <= IDLE;
                    end
                end
                FLUSH: begin
                    // terminal count ends the window; the held request is taken next cycle
                    if (flushCnt == 3'd0) begin
                        state <= IDLE;
                        flush <= 1'b0;
                    end else begin
                        flushCnt <= flushCnt - 3'd1;
                    end
                end
                default: begin
                    state <= IDLE;
                    flush <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_count  <= '0;
            mis_count <= '0;
        end else if (cnt_clr) begin
            br_count  <= '0;
            mis_count <= '0;
        end else if (accept && isLegal) begin
            if (br_count != CNT_MAX) br_count <= br_count + 1'b1;
            if (isMis && (mis_count != CNT_MAX)) mis_count <= mis_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// Bench for branch_resolver: directed scenarios plus random traffic against a
// cycle-level behavioural model; a narrow-counter instance covers saturation.
module tb_branch_resolver;
    localparam int XLEN = 32;
    localparam int FC   = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        brValid, brPred, brEq, brLt, cntClr;
    logic [2:0]  brF3;
    logic [31:0] brPc, brImm;

    logic        brReady, brUn, resValid, resTaken, resMis, resIll, flushO;
    logic [31:0] resTarget;
    logic [15:0] brCount, misCount;

    logic        brReady2, brUn2, resValid2, resTaken2, resMis2, resIll2, flush2;
    logic [31:0] resTarget2;
    logic [3:0]  brCount2, misCount2;

    branch_resolver #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .br_valid(brValid), .br_ready(brReady),
        .br_funct3(brF3), .br_pc(brPc), .br_imm(brImm), .br_pred_taken(brPred),
        .BrUn(brUn), .BrEq(brEq), .BrLT(brLt),
        .res_valid(resValid), .res_taken(resTaken), .res_target(resTarget),
        .res_mispredict(resMis), .res_illegal(resIll), .flush(flushO),
        .cnt_clr(cntClr), .br_count(brCount), .mis_count(misCount));

    branch_resolver #(.XLEN(XLEN), .FLUSH_CYCLES(FC), .CNT_W(4)) dutNarrow (
        .clk(clk), .rst_n(rst_n), .br_valid(brValid), .br_ready(brReady2),
        .br_funct3(brF3), .br_pc(brPc), .br_imm(brImm), .br_pred_taken(brPred),
        .BrUn(brUn2), .BrEq(brEq), .BrLT(brLt),
        .res_valid(resValid2), .res_taken(resTaken2), .res_target(resTarget2),
        .res_mispredict(resMis2), .res_illegal(resIll2), .flush(flush2),
        .cnt_clr(cntClr), .br_count(brCount2), .mis_count(misCount2));

    int checks = 0;
    int failures = 0;

    // behavioural model state
    logic        expValid, expTaken, expMis, expIll;
    logic [31:0] expTarget;
    int          flushLeft;
    int          expBr, expMisCnt, expBr2, expMis2;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic refTaken(input logic [2:0] f3, input logic eq, input logic lt);
        case (f3)
            3'd0: return eq;
            3'd1: return !eq;
            3'd4, 3'd6: return lt;
            3'd5, 3'd7: return !lt;
            default: return 1'b0;
        endcase
    endfunction

    task automatic modelReset();
        expValid = 0; expTaken = 0; expMis = 0; expIll = 0; expTarget = 0;
        flushLeft = 0; expBr = 0; expMisCnt = 0; expBr2 = 0; expMis2 = 0;
    endtask

    task automatic checkOutputs();
        chk("res_valid", 32'(resValid), 32'(expValid));
        chk("res_taken", 32'(resTaken), 32'(expTaken));
        chk("res_target", resTarget, expTarget);
        chk("res_mispredict", 32'(resMis), 32'(expMis));
        chk("res_illegal", 32'(resIll), 32'(expIll));
        chk("flush", 32'(flushO), 32'(flushLeft > 0));
        chk("br_count", 32'(brCount), 32'(expBr));
        chk("mis_count", 32'(misCount), 32'(expMisCnt));
        chk("br_count_narrow", 32'(brCount2), 32'(expBr2));
        chk("mis_count_narrow", 32'(misCount2), 32'(expMis2));
    endtask

    // one clock of traffic: drive, check combinational outputs, clock, update model, check
    task automatic step(input logic v, input logic [2:0] f3, input logic [31:0] pc,
                        input logic [31:0] imm, input logic pred, input logic eq,
                        input logic lt, input logic clr);
        logic acc, legal, tk;
        brValid = v; brF3 = f3; brPc = pc; brImm = imm; brPred = pred;
        brEq = eq; brLt = lt; cntClr = clr;
        #1;
        chk("BrUn", 32'(brUn), 32'(f3[1]));
        chk("br_ready", 32'(brReady), 32'(flushLeft == 0));
        acc = v && (flushLeft == 0);
        legal = !(f3 == 3'd2 || f3 == 3'd3);
        @(posedge clk);
        if (flushLeft > 0) flushLeft--;
        expValid = acc;
        if (acc) begin
            tk = legal ? refTaken(f3, eq, lt) : 1'b0;
            expTaken = tk;
            expTarget = tk ? pc + imm : pc + 32'd4;
            expIll = !legal;
            expMis = legal && (tk != pred);
            if (expMis) flushLeft = FC;
        end
        if (clr) begin
            expBr = 0; expMisCnt = 0; expBr2 = 0; expMis2 = 0;
        end else if (acc && legal) begin
            if (expBr < 65535) expBr++;
            if (expBr2 < 15) expBr2++;
            if (expMis && expMisCnt < 65535) expMisCnt++;
            if (expMis && expMis2 < 15) expMis2++;
        end
        #1;
        checkOutputs();
    endtask

    task automatic idle();
        step(1'b0, 3'd0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        brValid = 0; brF3 = 0; brPc = 0; brImm = 0; brPred = 0; brEq = 0; brLt = 0; cntClr = 0;
        #1;
        chk("flush_in_reset", 32'(flushO), 32'd0);
        chk("ready_in_reset", 32'(brReady), 32'd0);
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        checkOutputs();
    endtask

    initial begin
        int b0, m0;
        modelReset();
        applyReset();

        // BEQ taken, correctly predicted
        step(1'b1, 3'd0, 32'h100, 32'h20, 1'b1, 1'b1, 1'b0, 1'b0);
        chk("beq_target", resTarget, 32'h120);
        chk("beq_taken", 32'(resTaken), 32'd1);
        chk("beq_br_count", 32'(brCount), 32'd1);

        // BLTU not taken against taken prediction -> two-cycle flush
        step(1'b1, 3'd6, 32'h200, 32'h40, 1'b1, 1'b0, 1'b0, 1'b0);
        chk("bltu_target", resTarget, 32'h204);
        chk("bltu_mis", 32'(resMis), 32'd1);
        chk("bltu_flush1", 32'(flushO), 32'd1);
        chk("bltu_ready1", 32'(brReady), 32'd0);
        idle();
        chk("bltu_flush2", 32'(flushO), 32'd1);
        chk("bltu_valid_drop", 32'(resValid), 32'd0);
        idle();
        chk("bltu_flush_end", 32'(flushO), 32'd0);
        chk("bltu_mis_count", 32'(misCount), 32'd1);

        // back-to-back correctly predicted BNE
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'd1, 32'h300 + 32'(4 * i), 32'h10, 1'b1, 1'b0, 1'b0, 1'b0);
            chk("b2b_valid", 32'(resValid), 32'd1);
            chk("b2b_ready", 32'(brReady), 32'd1);
        end
        chk("b2b_br_count", 32'(brCount), 32'd5);

        // request held through a flush, then accepted; PC wrap on not-taken
        step(1'b1, 3'd0, 32'h400, 32'h8, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'd0, 32'hFFFF_FFFC, 32'h8, 1'b0, 1'b0, 1'b0, 1'b0);
            chk("held_valid", 32'(resValid), (i == 2) ? 32'd1 : 32'd0);
        end
        chk("wrap_target", resTarget, 32'h0000_0000);

        // illegal funct3
        b0 = expBr; m0 = expMisCnt;
        step(1'b1, 3'd2, 32'h500, 32'h40, 1'b1, 1'b1, 1'b1, 1'b0);
        chk("ill_flag", 32'(resIll), 32'd1);
        chk("ill_taken", 32'(resTaken), 32'd0);
        chk("ill_flush", 32'(flushO), 32'd0);
        chk("ill_br_count", 32'(brCount), 32'(b0));
        chk("ill_mis_count", 32'(misCount), 32'(m0));

        // clear wins over a coincident mispredicting accept
        step(1'b1, 3'd0, 32'h600, 32'h4, 1'b0, 1'b1, 1'b0, 1'b1);
        chk("clr_br_count", 32'(brCount), 32'd0);
        chk("clr_mis_count", 32'(misCount), 32'd0);
        idle(); idle();

        // saturation on the 4-bit counter instance
        for (int i = 0; i < 20; i++)
            step(1'b1, 3'd5, 32'h700, 32'h4, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("sat_br_count_narrow", 32'(brCount2), 32'hF);
        chk("sat_br_count", 32'(brCount), 32'd20);

        // reset mid-flush
        step(1'b1, 3'd4, 32'h800, 32'h4, 1'b0, 1'b0, 1'b1, 1'b0);
        chk("pre_rst_flush", 32'(flushO), 32'd1);
        applyReset();
        chk("post_rst_ready", 32'(brReady), 32'd1);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            step(($urandom_range(3) != 0), 3'($urandom_range(7)),
                 (i % 50 == 7) ? 32'hFFFF_FFFC : $urandom, $urandom,
                 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
                 ($urandom_range(63) == 0));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
